tt_sweep_capture: RTL and testbench

//   Drives a combinational or pipelined N_IN-input boolean function block with all
//   2**N_IN input patterns, then collects its single-bit output into a truth table.

---
 rtl/tt_sweep_capture_pkg.sv | 19 +
 rtl/tt_sweep_capture_if.sv | 27 ++
 rtl/tt_sweep_capture_delay_line.sv | 47 ++++
 rtl/tt_sweep_capture.sv | 122 ++++++++++++
 tb/tb_tt_sweep_capture.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_capture_pkg.sv
// Shared types and constants for the truth-table sweep/capture block.
package tt_pkg;

  localparam int unsigned N_IN_DEF = 7;
  localparam int unsigned MAX_LAT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } tt_state_e;

  // Truth-table width for an n-input function.
  function automatic int unsigned tt_bits(input int unsigned n);
    return 32'(1) << n;
  endfunction

endpackage

// File: rtl/tt_sweep_capture_if.sv
// Bus between the sweep/capture block and its controller and function-under-test.
interface tt_sweep_capture_if #(
  parameter int unsigned N_IN = tt_pkg::N_IN_DEF
) ();

  localparam int unsigned TT_BITS = tt_pkg::tt_bits(N_IN);

  logic                start;
  logic [TT_BITS-1:0]  expected;
  logic [N_IN-1:0]     x;
  logic                f_in;
  logic                busy;
  logic                done;
  logic [TT_BITS-1:0]  tt_out;
  logic                match;

  modport master (
    output start, expected, f_in,
    input  x, busy, done, tt_out, match
  );

  modport slave (
    input  start, expected, f_in,
    output x, busy, done, tt_out, match
  );

endinterface

// File: rtl/tt_sweep_capture_delay_line.sv
// Valid+index pipeline that tracks which pattern the FUT output belongs to.
module tt_delay_line #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_idx,
  output logic             out_valid_c,
  output logic [WIDTH-1:0] out_idx_c
);

  if (DEPTH == 0) begin : g_pass
    logic unused_c;
    assign unused_c    = clk ^ rst;
    assign out_valid_c = in_valid;
    assign out_idx_c   = in_idx;
  end else begin : g_pipe
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [WIDTH-1:0] idx_q [DEPTH];
    logic [WIDTH-1:0] idx_d [DEPTH];

    always_comb begin
      vld_d[0] = in_valid;
      idx_d[0] = in_idx;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_d[i] = vld_q[i-1];
        idx_d[i] = idx_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q <= '0;
        for (int i = 0; i < int'(DEPTH); i++) idx_q[i] <= '0;
      end else begin
        vld_q <= vld_d;
        idx_q <= idx_d;
      end
    end

    assign out_valid_c = vld_q[DEPTH-1];
    assign out_idx_c   = idx_q[DEPTH-1];
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Sweeps all input patterns through a function-under-test and captures its truth table,
// then compares the table against a reference latched at start.
module tt_sweep_capture
  import tt_pkg::*;
#(
  parameter int unsigned N_IN = N_IN_DEF,
  parameter int unsigned LAT  = 0
) (
  input logic               clk,
  input logic               rst,
  tt_sweep_capture_if.slave bus
);

  localparam int unsigned TT_BITS  = tt_bits(N_IN);
  localparam int unsigned DL_DEPTH = (LAT > MAX_LAT) ? MAX_LAT : LAT;

  localparam logic [1:0] IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] SWEEP = 2'(ST_SWEEP);
  localparam logic [1:0] DRAIN = 2'(ST_DRAIN);
  localparam logic [1:0] DONE  = 2'(ST_DONE);

  localparam logic [N_IN-1:0] IDX_LAST = '1;

  logic [1:0]         state_q, state_d;
  logic [N_IN-1:0]    x_q, x_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [TT_BITS-1:0] tt_q, tt_d;
  logic               match_q, match_d;
  logic [TT_BITS-1:0] exp_q, exp_d;

  logic               issue_valid_c;
  logic               cap_valid_c;
  logic [N_IN-1:0]    cap_idx_c;
  logic               start_ok_c;
  logic               last_cap_c;

  assign issue_valid_c = (state_q == SWEEP);
  assign start_ok_c    = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign last_cap_c    = cap_valid_c && (cap_idx_c == IDX_LAST);

  // Index follows the FUT latency so each returning bit lands in its own slot.
  tt_delay_line #(
    .WIDTH (N_IN),
    .DEPTH (DL_DEPTH)
  ) u_delay_line (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (issue_valid_c),
    .in_idx      (x_q),
    .out_valid_c (cap_valid_c),
    .out_idx_c   (cap_idx_c)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tt_d    = tt_q;
    match_d = match_q;
    exp_d   = exp_q;

    if (cap_valid_c) tt_d[cap_idx_c] = bus.f_in;

    case (state_q)
      IDLE, DONE: begin
        if (start_ok_c) begin
          state_d = SWEEP;
          x_d     = '0;
          busy_d  = 1'b1;
          tt_d    = '0;
          match_d = 1'b0;
          exp_d   = bus.expected;
        end
      end
      SWEEP: begin
        if (x_q != IDX_LAST) x_d = x_q + N_IN'(1);
        // With no FUT latency the last capture coincides with the last issue.
        if (last_cap_c)            state_d = DONE;
        else if (x_q == IDX_LAST)  state_d = DRAIN;
      end
      DRAIN: begin
        if (last_cap_c) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    if (last_cap_c) begin
      done_d  = 1'b1;
      busy_d  = 1'b0;
      match_d = (tt_d == exp_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      match_q <= 1'b0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      match_q <= match_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.x      = x_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.tt_out = tt_q;
  assign bus.match  = match_q;

endmodule

// File: tb/tb_tt_sweep_capture.sv
// Bench for tt_sweep_capture: a combinational DUT (LAT=0) and a pipelined DUT (LAT=2).
module tb_tt_sweep_capture;

  localparam logic [127:0] REF_TT  = 128'hfeeaece8fae8e8a0fae8e8a0e8c8a880;
  localparam logic [127:0] ALT_TT  = {64{2'b10}};
  localparam logic [127:0] HIGH_TT = {{64{1'b1}}, {64{1'b0}}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int           sel   [2];
  logic         start_s [2];
  logic [127:0] exp_s [2];

  tt_sweep_capture_if #(.N_IN(7)) if0 ();
  tt_sweep_capture_if #(.N_IN(7)) if2 ();

  // FUT menu: 0 = x[0], 1 = reference table, 2 = constant 0, 3 = x[6]
  function automatic logic fut_fn(input int s, input logic [6:0] i);
    logic [127:0] t;
    t = REF_TT;
    case (s)
      0:       return i[0];
      1:       return t[i];
      3:       return i[6];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [127:0] build_tt(input int s);
    logic [127:0] r;
    for (int i = 0; i < 128; i++) r[i] = fut_fn(s, 7'(i));
    return r;
  endfunction

  assign if0.start    = start_s[0];
  assign if0.expected = exp_s[0];
  assign if0.f_in     = fut_fn(sel[0], if0.x);

  logic p1 = 1'b0, p2 = 1'b0;
  always @(posedge clk) begin
    p1 <= fut_fn(sel[1], if2.x);
    p2 <= p1;
  end
  assign if2.start    = start_s[1];
  assign if2.expected = exp_s[1];
  assign if2.f_in     = p2;

  tt_sweep_capture #(.N_IN(7), .LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  tt_sweep_capture #(.N_IN(7), .LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [6:0]   o_x     [2];
  logic         o_busy  [2];
  logic         o_done  [2];
  logic [127:0] o_tt    [2];
  logic         o_match [2];
  assign o_x[0] = if0.x;      assign o_x[1] = if2.x;
  assign o_busy[0] = if0.busy; assign o_busy[1] = if2.busy;
  assign o_done[0] = if0.done; assign o_done[1] = if2.done;
  assign o_tt[0] = if0.tt_out; assign o_tt[1] = if2.tt_out;
  assign o_match[0] = if0.match; assign o_match[1] = if2.match;

  // Model: k = cycles since the accepted start (first cycle after the accepting edge is 1)
  bit           chk_en = 1'b0;
  bit           act  [2];
  int           k    [2];
  logic [127:0] tbl  [2];
  logic [127:0] mexp [2];

  always @(posedge clk) begin
    if (rst) chk_en <= 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        act[d] <= 1'b0;
        k[d]   <= 0;
      end else if (start_s[d] && (!act[d] || k[d] >= 129 + 2*d)) begin
        act[d]  <= 1'b1;
        k[d]    <= 1;
        tbl[d]  <= build_tt(sel[d]);
        mexp[d] <= exp_s[d];
      end else if (act[d]) begin
        k[d] <= k[d] + 1;
      end
    end
  end

  // Hand-computed expectations pinned at each sweep's done pulse
  bit           lit_en    [2];
  int           lit_lat   [2];
  logic [127:0] lit_tt    [2];
  logic         lit_match [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int d, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, d, $time, got, want);
    end
  endtask

  always @(negedge clk) begin : cmp
    int           lat;
    logic [127:0] wtt;
    logic [6:0]   wx;
    logic         wb, wd, wm;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        lat = 2 * d;
        wx  = !act[d] ? 7'd0 : ((k[d] - 1 >= 127) ? 7'd127 : 7'(k[d] - 1));
        wb  = act[d] && (k[d] <= 128 + lat);
        wd  = act[d] && (k[d] == 129 + lat);
        wm  = act[d] && (k[d] >= 129 + lat) && (tbl[d] == mexp[d]);
        wtt = '0;
        for (int i = 0; i < 128; i++)
          if (act[d] && (i <= k[d] - 2 - lat)) wtt[i] = tbl[d][i];
        chk("x",      d, 128'(o_x[d]),     128'(wx));
        chk("busy",   d, 128'(o_busy[d]),  128'(wb));
        chk("done",   d, 128'(o_done[d]),  128'(wd));
        chk("tt_out", d, o_tt[d],          wtt);
        chk("match",  d, 128'(o_match[d]), 128'(wm));
        if (o_done[d] && lit_en[d]) begin
          chk("done_latency", d, 128'(k[d]),       128'(lit_lat[d]));
          chk("tt_literal",   d, o_tt[d],          lit_tt[d]);
          chk("match_lit",    d, 128'(o_match[d]), 128'(lit_match[d]));
        end
      end
    end
  end

  task automatic setup(input int d, input int s, input logic [127:0] e,
                       input int lat, input logic [127:0] tt, input logic m);
    #1;
    sel[d]       = s;
    exp_s[d]     = e;
    lit_en[d]    = 1'b1;
    lit_lat[d]   = lat;
    lit_tt[d]    = tt;
    lit_match[d] = m;
  endtask

  // Returns in the done cycle (or right after a mid-sweep reset).
  task automatic run_sweep(input int d, input int poke_at, input int rst_at);
    int n;
    if (!start_s[d]) begin
      @(negedge clk);
      start_s[d] = 1'b1;
    end
    @(negedge clk);
    start_s[d] = 1'b0;
    for (n = 1; n < 400; n++) begin
      if (o_done[d]) break;
      if (n == poke_at) begin
        start_s[d] = 1'b1;
        exp_s[d]   = ~exp_s[d];
      end else if (n == poke_at + 1) begin
        start_s[d] = 1'b0;
      end
      if (n == rst_at) rst = 1'b1;
      if (n == rst_at + 1) begin
        rst = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (n >= 400) begin
      $display("FAIL done_timeout dut%0d t=%0t got=no-done want=done", d, $time);
      $fatal(1, "done never arrived");
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      sel[d] = 0; start_s[d] = 1'b0; exp_s[d] = '0;
      lit_en[d] = 1'b0; lit_lat[d] = 0; lit_tt[d] = '0; lit_match[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    setup(0, 0, ALT_TT, 129, ALT_TT, 1'b1);
    run_sweep(0, -1, -1);

    // Next start lands in the done cycle of the previous sweep
    setup(0, 1, REF_TT, 129, REF_TT, 1'b1);
    start_s[0] = 1'b1;
    run_sweep(0, -1, -1);

    setup(0, 2, '1, 129, '0, 1'b0);
    run_sweep(0, -1, -1);
    repeat (6) @(negedge clk);

    setup(1, 3, HIGH_TT, 131, HIGH_TT, 1'b1);
    run_sweep(1, -1, -1);
    repeat (4) @(negedge clk);

    setup(0, 0, ALT_TT, 129, ALT_TT, 1'b1);
    run_sweep(0, 40, -1);

    setup(0, 1, REF_TT, 129, REF_TT, 1'b1);
    run_sweep(0, -1, 60);
    repeat (3) @(negedge clk);

    setup(0, 1, REF_TT, 129, REF_TT, 1'b1);
    run_sweep(0, -1, -1);
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
